// File: rtl/demux_16line_8bit.sv
// -----------------------------------------------------------------------------
// demux_16line_8bit
//
// Purpose:
//   Sixteen registered 8-bit lines. A data byte is written to one line per
//   cycle, either to the line picked by sel (direct mode) or to the line
//   pointed at by an internal auto-increment pointer (auto mode). A clear
//   request launches a 16-cycle sweep that zeroes every line in turn. While
//   the sweep runs, write and clear requests are ignored.
//
// Ports:
//   clk          in   1   system clock, rising edge active
//   clr_n        in   1   synchronous active-low reset
//   in           in   8   data byte to write
//   sel          in   4   target line for direct writes
//   we           in   1   write strobe, one write per cycle while high
//   auto         in   1   1 = write to line[ptr] and advance ptr
//   clear        in   1   single-cycle request to start the clear sweep
//   out0..out15  out  8   registered contents of line 0..15
//   ptr          out  4   auto-write pointer
//   busy         out  1   high while the clear sweep is running
// -----------------------------------------------------------------------------
module demux_16line_8bit (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] in,
    input  logic [3:0] sel,
    input  logic       we,
    input  logic       auto,
    input  logic       clear,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic [7:0] out4,
    output logic [7:0] out5,
    output logic [7:0] out6,
    output logic [7:0] out7,
    output logic [7:0] out8,
    output logic [7:0] out9,
    output logic [7:0] out10,
    output logic [7:0] out11,
    output logic [7:0] out12,
    output logic [7:0] out13,
    output logic [7:0] out14,
    output logic [7:0] out15,
    output logic [3:0] ptr,
    output logic       busy
);

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sweepCnt_q, sweepCnt_d;
    logic [3:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;
    logic [7:0] lines_q [16];
    logic [7:0] lines_d [16];

    // State register plus every other piece of state. Reset is sampled on
    // the clock edge and overrides everything, including a sweep in flight.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            sweepCnt_q <= 4'd0;
            ptr_q      <= 4'd0;
            busy_q     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                lines_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            sweepCnt_q <= sweepCnt_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            for (int i = 0; i < 16; i++) begin
                lines_q[i] <= lines_d[i];
            end
        end
    end

    // Next-state logic. A clear request in IDLE wins over any write in the
    // same cycle; once sweeping, only the sweep counter decides the exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEARING;
                end
            end
            CLEARING: begin
                if (sweepCnt_q == 4'd15) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output logic. busy is registered alongside the state so it
    // changes only on clock edges and is high exactly while in CLEARING.
    always_comb begin
        lines_d    = lines_q;
        ptr_d      = ptr_q;
        sweepCnt_d = sweepCnt_q;
        busy_d     = (state_d == CLEARING);
        case (state_q)
            IDLE: begin
                if (clear) begin
                    sweepCnt_d = 4'd0;
                end else if (we) begin
                    if (auto) begin
                        lines_d[ptr_q] = in;
                        ptr_d          = ptr_q + 4'd1;
                    end else begin
                        lines_d[sel] = in;
                    end
                end
            end
            CLEARING: begin
                // The sweep is deaf to we/clear; it only zeroes its own line.
                lines_d[sweepCnt_q] = 8'h00;
                sweepCnt_d          = sweepCnt_q + 4'd1;
                if (sweepCnt_q == 4'd15) begin
                    ptr_d = 4'd0;
                end
            end
            default: begin
                sweepCnt_d = 4'd0;
            end
        endcase
    end

    // Each output port is a straight wire from its line register.
    assign out0  = lines_q[0];
    assign out1  = lines_q[1];
    assign out2  = lines_q[2];
    assign out3  = lines_q[3];
    assign out4  = lines_q[4];
    assign out5  = lines_q[5];
    assign out6  = lines_q[6];
    assign out7  = lines_q[7];
    assign out8  = lines_q[8];
    assign out9  = lines_q[9];
    assign out10 = lines_q[10];
    assign out11 = lines_q[11];
    assign out12 = lines_q[12];
    assign out13 = lines_q[13];
    assign out14 = lines_q[14];
    assign out15 = lines_q[15];
    assign ptr   = ptr_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_demux_16line_8bit.sv
// -----------------------------------------------------------------------------
// tb_demux_16line_8bit
//
// Purpose:
//   Self-checking bench for demux_16line_8bit. Every driven cycle pushes the
//   expected post-edge snapshot (all lines, ptr, busy) from a behavioural
//   model onto a scoreboard queue; each test pops and compares after the
//   edge. Tests also compare selected lines against fixed constants.
// -----------------------------------------------------------------------------
module tb_demux_16line_8bit;

    logic       clk;
    logic       clr_n;
    logic [7:0] in;
    logic [3:0] sel;
    logic       we;
    logic       auto;
    logic       clear;
    logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0] out8, out9, out10, out11, out12, out13, out14, out15;
    logic [3:0] ptr;
    logic       busy;

    typedef struct packed {
        logic [127:0] lines;
        logic [3:0]   ptr;
        logic         busy;
    } snap_t;

    snap_t      sb[$];
    logic [7:0] mLines [16];
    logic [3:0] mPtr;
    logic [3:0] mCnt;
    logic       mBusy;
    int         total;
    int         bad;

    demux_16line_8bit dut (
        .clk   (clk),
        .clr_n (clr_n),
        .in    (in),
        .sel   (sel),
        .we    (we),
        .auto  (auto),
        .clear (clear),
        .out0  (out0),
        .out1  (out1),
        .out2  (out2),
        .out3  (out3),
        .out4  (out4),
        .out5  (out5),
        .out6  (out6),
        .out7  (out7),
        .out8  (out8),
        .out9  (out9),
        .out10 (out10),
        .out11 (out11),
        .out12 (out12),
        .out13 (out13),
        .out14 (out14),
        .out15 (out15),
        .ptr   (ptr),
        .busy  (busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic snap_t modelSnap();
        snap_t s;
        for (int i = 0; i < 16; i++) begin
            s.lines[i*8 +: 8] = mLines[i];
        end
        s.ptr  = mPtr;
        s.busy = mBusy;
        return s;
    endfunction

    function automatic snap_t dutSnap();
        snap_t s;
        s.lines = {out15, out14, out13, out12, out11, out10, out9, out8,
                   out7, out6, out5, out4, out3, out2, out1, out0};
        s.ptr   = ptr;
        s.busy  = busy;
        return s;
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expectation,
    // then step past the edge so the caller samples settled outputs.
    task automatic applyStimulus(input logic iClrn, input logic iWe,
                                 input logic iAuto, input logic [3:0] iSel,
                                 input logic [7:0] iIn, input logic iClear);
        clr_n = iClrn;
        we    = iWe;
        auto  = iAuto;
        sel   = iSel;
        in    = iIn;
        clear = iClear;
        if (!iClrn) begin
            for (int i = 0; i < 16; i++) mLines[i] = 8'h00;
            mPtr  = 4'd0;
            mCnt  = 4'd0;
            mBusy = 1'b0;
        end else if (mBusy) begin
            mLines[mCnt] = 8'h00;
            if (mCnt == 4'd15) begin
                mBusy = 1'b0;
                mPtr  = 4'd0;
                mCnt  = 4'd0;
            end else begin
                mCnt = mCnt + 4'd1;
            end
        end else if (iClear) begin
            mBusy = 1'b1;
            mCnt  = 4'd0;
        end else if (iWe) begin
            if (iAuto) begin
                mLines[mPtr] = iIn;
                mPtr         = mPtr + 4'd1;
            end else begin
                mLines[iSel] = iIn;
            end
        end
        sb.push_back(modelSnap());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t e, g;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 8'h99, 1'b0);
        e = sb.pop_front(); g = dutSnap(); total++;
        if (g !== e) begin
            bad++; $display("[TB] FAIL reset_state got=%h exp=%h", g, e);
        end
        total++;
        if ({out2, ptr, busy} !== 13'd0) begin
            bad++; $display("[TB] FAIL reset_zero got=%h exp=%h", {out2, ptr, busy}, 13'd0);
        end
    endtask

    task automatic test_direct();
        snap_t e, g;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, k[3:0], 8'(k + 16), 1'b0);
            e = sb.pop_front(); g = dutSnap(); total++;
            if (g !== e) begin
                bad++; $display("[TB] FAIL direct k=%0d got=%h exp=%h", k, g, e);
            end
            total++;
            if (g.lines[k*8 +: 8] !== 8'(k + 16)) begin
                bad++; $display("[TB] FAIL direct_line k=%0d got=%h exp=%h", k, g.lines[k*8 +: 8], 8'(k + 16));
            end
        end
    endtask

    task automatic test_auto();
        snap_t e, g;
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 4'(15 - (k % 16)), 8'(8'hA0 + k), 1'b0);
            e = sb.pop_front(); g = dutSnap(); total++;
            if (g !== e) begin
                bad++; $display("[TB] FAIL auto k=%0d got=%h exp=%h", k, g, e);
            end
        end
        total++;
        if ({out0, out1, out15, ptr} !== {8'hB0, 8'hA1, 8'hAF, 4'd1}) begin
            bad++; $display("[TB] FAIL auto_wrap got=%h exp=%h", {out0, out1, out15, ptr}, {8'hB0, 8'hA1, 8'hAF, 4'd1});
        end
    endtask

    task automatic test_clear_wins();
        snap_t e, g;
        int busyCnt;
        busyCnt = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd3, 8'h55, 1'b1);
        e = sb.pop_front(); g = dutSnap(); total++;
        if (g !== e) begin
            bad++; $display("[TB] FAIL clear_start got=%h exp=%h", g, e);
        end
        total++;
        if (out3 !== 8'hA3) begin
            bad++; $display("[TB] FAIL clear_wins_line3 got=%h exp=%h", out3, 8'hA3);
        end
        if (busy) busyCnt++;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
            e = sb.pop_front(); g = dutSnap(); total++;
            if (g !== e) begin
                bad++; $display("[TB] FAIL clear_sweep i=%0d got=%h exp=%h", i, g, e);
            end
            if (busy) busyCnt++;
        end
        total++;
        if (busyCnt !== 16) begin
            bad++; $display("[TB] FAIL clear_busy_len got=%0d exp=%0d", busyCnt, 16);
        end
        total++;
        if ({dutSnap().lines, ptr} !== 132'd0) begin
            bad++; $display("[TB] FAIL clear_all_zero got=%h exp=0", {dutSnap().lines, ptr});
        end
        // Write in the first idle cycle after busy falls.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 8'h77, 1'b0);
        e = sb.pop_front(); g = dutSnap(); total++;
        if (g !== e || out5 !== 8'h77) begin
            bad++; $display("[TB] FAIL write_after_busy got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_busy_ignore();
        snap_t e, g;
        int busyCnt;
        busyCnt = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        e = sb.pop_front(); g = dutSnap(); total++;
        if (g !== e) begin
            bad++; $display("[TB] FAIL ignore_start got=%h exp=%h", g, e);
        end
        if (busy) busyCnt++;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, i[0], i[3:0], 8'hEE, (i % 3) == 0);
            e = sb.pop_front(); g = dutSnap(); total++;
            if (g !== e) begin
                bad++; $display("[TB] FAIL ignore_sweep i=%0d got=%h exp=%h", i, g, e);
            end
            if (busy) busyCnt++;
        end
        total++;
        if (busyCnt !== 16) begin
            bad++; $display("[TB] FAIL ignore_busy_len got=%0d exp=%0d", busyCnt, 16);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
        e = sb.pop_front(); g = dutSnap(); total++;
        if (g !== e || busy !== 1'b0 || ptr !== 4'd0) begin
            bad++; $display("[TB] FAIL ignore_no_restart got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_reset_mid_sweep();
        snap_t e, g;
        for (int k = 8; k < 16; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, k[3:0], 8'hFF, 1'b0);
            e = sb.pop_front(); g = dutSnap(); total++;
            if (g !== e) begin
                bad++; $display("[TB] FAIL mid_fill k=%0d got=%h exp=%h", k, g, e);
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0);
            e = sb.pop_front(); g = dutSnap(); total++;
            if (g !== e) begin
                bad++; $display("[TB] FAIL mid_sweep i=%0d got=%h exp=%h", i, g, e);
            end
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd4, 8'h12, 1'b1);
        e = sb.pop_front(); g = dutSnap(); total++;
        if (g !== e || {g.lines, g.ptr, g.busy} !== 133'd0) begin
            bad++; $display("[TB] FAIL mid_reset got=%h exp=%h", g, e);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd9, 8'h42, 1'b0);
        e = sb.pop_front(); g = dutSnap(); total++;
        if (g !== e || out9 !== 8'h42 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_write_after got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_back_to_back();
        snap_t e, g;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd15, 8'hFF, 1'b0);
        e = sb.pop_front(); g = dutSnap(); total++;
        if (g !== e) begin
            bad++; $display("[TB] FAIL b2b_first got=%h exp=%h", g, e);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, 8'h3C, 1'b0);
        e = sb.pop_front(); g = dutSnap(); total++;
        if (g !== e) begin
            bad++; $display("[TB] FAIL b2b_second got=%h exp=%h", g, e);
        end
        total++;
        if ({out15, out0, out9, out1} !== {8'hFF, 8'h3C, 8'h42, 8'h00}) begin
            bad++; $display("[TB] FAIL b2b_lines got=%h exp=%h", {out15, out0, out9, out1}, {8'hFF, 8'h3C, 8'h42, 8'h00});
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 4'(i), 8'h5A, 1'b0);
            e = sb.pop_front(); g = dutSnap(); total++;
            if (g !== e) begin
                bad++; $display("[TB] FAIL hold i=%0d got=%h exp=%h", i, g, e);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr_n = 1'b0;
        in    = 8'h00;
        sel   = 4'd0;
        we    = 1'b0;
        auto  = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 16; i++) mLines[i] = 8'h00;
        mPtr  = 4'd0;
        mCnt  = 4'd0;
        mBusy = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_direct();
        test_auto();
        test_clear_wins();
        test_busy_ignore();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_16line_8bit.md
DEMUX_16LINE_8BIT -- requirements
Module: demux_16line_8bit

Interface
REQ-001 SHALL: clk  input  1  system clock; all state updates on the rising edge.
REQ-002 SHALL: clr_n  input  1  reset, synchronous, active-low; one clock, sampled on rising edge of clk.
REQ-003 SHALL: in  input  8  data byte to be written to one output line.
REQ-004 SHALL: sel  input  4  target line index for direct writes (auto=0).
REQ-005 SHALL: we  input  1  write strobe; one write per cycle while high.
REQ-006 SHALL: auto  input  1  1 = write target is internal pointer ptr, not sel.
REQ-007 SHALL: clear  input  1  single-cycle request to start the clear sweep.
REQ-008 SHALL: out0..out15  output  8 each  registered line contents (out<k> holds line k).
REQ-009 SHALL: ptr  output  4  auto-write pointer, registered.
REQ-010 SHALL: busy  output  1  high while the clear sweep is running.

Function
REQ-011 SHALL: hold 16 x 8-bit registers; out<k> drives register k directly, no combinational path from in/sel to any out<k>.
REQ-012 SHALL: FSM states: IDLE, CLEARING; busy = (state == CLEARING), registered.
REQ-013 SHALL: in IDLE with we=1, auto=0, clear=0: line[sel] <= in at the edge; new value visible on out<sel> the cycle after (latency 1); all other lines unchanged.
REQ-014 SHALL: in IDLE with we=1, auto=1, clear=0: line[ptr] <= in and ptr <= ptr+1 modulo 16 (15 wraps to 0); sel ignored.
REQ-015 SHALL: ptr change only on auto writes, the clear sweep and reset; direct writes leave ptr unchanged.
REQ-016 SHALL: in IDLE with clear=1: enter CLEARING next edge, internal sweep counter = 0, any simultaneous we dropped (clear wins).
REQ-017 SHALL: in CLEARING: each cycle zero line[counter], increment counter; after line 15 is zeroed return to IDLE; sweep takes exactly 16 cycles, busy high for exactly 16 cycles.
REQ-018 SHALL: in CLEARING: ignore we and clear entirely (no line write, no ptr change, no restart).
REQ-019 SHALL: set ptr to 0 on the edge that returns CLEARING -> IDLE.
REQ-020 SHALL: accept a write in the first IDLE cycle after busy falls.
REQ-021 SHALL: we=0 and clear=0 in IDLE: all state held.

Reset
REQ-022 SHALL: on clr_n=0 at a rising edge: all 16 lines = 8'h00, ptr = 0, busy = 0, state = IDLE, sweep counter = 0.
REQ-023 SHALL: reset override every other input and abort a clear sweep mid-operation with the REQ-022 values.
REQ-024 SHALL: no output change between edges, including during reset.

Verification
REQ-025 SHALL: reset, then direct writes sel=k, in=k+16 for k=0..15 -> out<k> = k+16 one cycle after each write, other lines untouched.
REQ-026 SHALL: auto=1, 17 consecutive writes in=8'hA0..8'hB0 -> ptr runs 0..15 then wraps to 1; out0 = 8'hB0 (overwritten), out1..out15 = 8'hA1..8'hAF.
REQ-027 SHALL: clear=1 with we=1, sel=3, in=8'h55 in the same cycle -> line 3 not written, busy high 16 cycles, all outs 0 afterwards, ptr = 0.
REQ-028 SHALL: we=1, clear=1 pulsed during busy -> ignored; sweep length stays 16 cycles.
REQ-029 SHALL: clr_n=0 for one cycle at sweep cycle 7 with lines 8..15 = 8'hFF -> all outs 0, busy 0 next cycle, direct write accepted the following cycle.
REQ-030 SHALL: write sel=15, in=8'hFF, then sel=0 in back-to-back cycles -> out15 = 8'hFF, out0 = next value, no cross-line corruption.
